// File: rtl/alu_seq.sv
// alu_seq: single-command sequencer around an external fixed-latency ALU.
// Owns the accumulator (A) and status (P) registers and returns one response per command.
module alu_seq #(
    parameter int ALU_LAT = 2
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_cmd,
    input  logic [7:0] req_operand,
    input  logic       req_acc,
    output logic [3:0] alu_op,
    output logic [7:0] alu_acc,
    output logic [7:0] alu_operand,
    output logic [7:0] alu_status,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] a_out,
    output logic [7:0] p_out
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_ADC  = 4'd1;
    localparam logic [3:0] CMD_SBC  = 4'd2;
    localparam logic [3:0] CMD_AND  = 4'd3;
    localparam logic [3:0] CMD_EOR  = 4'd4;
    localparam logic [3:0] CMD_ORA  = 4'd5;
    localparam logic [3:0] CMD_BIT  = 4'd6;
    localparam logic [3:0] CMD_ASL  = 4'd7;
    localparam logic [3:0] CMD_LSR  = 4'd8;
    localparam logic [3:0] CMD_ROL  = 4'd9;
    localparam logic [3:0] CMD_ROR  = 4'd10;
    localparam logic [3:0] CMD_PASS = 4'd11;
    localparam logic [3:0] CMD_CLC  = 4'd12;
    localparam logic [3:0] CMD_SEC  = 4'd13;
    localparam logic [3:0] CMD_CLV  = 4'd14;
    localparam logic [3:0] CMD_PLP  = 4'd15;

    // P bit order: C Z I D B - V N
    localparam logic [7:0] MASK_ARITH = 8'hC3;
    localparam logic [7:0] MASK_LOGIC = 8'h41;
    localparam logic [7:0] MASK_BIT   = 8'h43;
    localparam logic [7:0] MASK_SHIFT = 8'hC1;
    localparam logic [7:0] P_RESET    = 8'h20;
    localparam logic [7:0] P_RSVD_CLR = 8'hFB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] cmd);
        return (cmd >= CMD_ASL) && (cmd <= CMD_ROR);
    endfunction

    function automatic logic [7:0] flag_mask(input logic [3:0] cmd);
        logic [7:0] m;
        case (cmd)
            CMD_ADD, CMD_ADC, CMD_SBC:           m = MASK_ARITH;
            CMD_AND, CMD_EOR, CMD_ORA, CMD_PASS: m = MASK_LOGIC;
            CMD_BIT:                             m = MASK_BIT;
            CMD_ASL, CMD_LSR, CMD_ROL, CMD_ROR:  m = MASK_SHIFT;
            default:                             m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic logic writes_acc(input logic [3:0] cmd, input logic acc_sel);
        logic w;
        case (cmd)
            CMD_ADD, CMD_ADC, CMD_SBC, CMD_AND,
            CMD_EOR, CMD_ORA, CMD_PASS:          w = 1'b1;
            CMD_ASL, CMD_LSR, CMD_ROL, CMD_ROR:  w = acc_sel;
            default:                             w = 1'b0;
        endcase
        return w;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       cmd_r;
    logic             acc_sel_r;
    logic [1:0]       bit_nv_r;
    logic [7:0]       a_r;
    logic [7:0]       p_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [7:0]       rsp_data_r;
    logic [3:0]       alu_op_r;
    logic [7:0]       alu_acc_r;
    logic [7:0]       alu_operand_r;
    logic [7:0]       alu_status_r;

    logic             accept_s;
    logic             commit_s;
    logic             flag_cmd_s;
    logic [7:0]       p_flag_s;
    logic [7:0]       calc_flags_s;
    logic [7:0]       p_commit_s;
    logic             a_write_s;
    logic             unused_flags_s;

    // ALU status bits other than C and V carry no meaning here
    assign unused_flags_s = ^{alu_flags[6:2], alu_flags[0]};

    assign flag_cmd_s = (req_cmd[3:2] == 2'b11);

    // Next-state decode and handshake strobes
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = flag_cmd_s ? ST_RESP : ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    commit_s     = 1'b1;
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // New P for the bypass commands, evaluated straight off the request
    always_comb begin
        p_flag_s = p_r;
        case (req_cmd)
            CMD_CLC: p_flag_s[7] = 1'b0;
            CMD_SEC: p_flag_s[7] = 1'b1;
            CMD_CLV: p_flag_s[1] = 1'b0;
            CMD_PLP: p_flag_s    = req_operand & P_RSVD_CLR;
            default: p_flag_s    = p_r;
        endcase
    end

    // Flags derived from the returned ALU result, merged under the op mask
    always_comb begin
        calc_flags_s    = 8'h00;
        calc_flags_s[7] = alu_flags[7];
        calc_flags_s[6] = (alu_result == 8'h00);
        if (cmd_r == CMD_BIT) begin
            calc_flags_s[1] = bit_nv_r[0];
            calc_flags_s[0] = bit_nv_r[1];
        end else begin
            calc_flags_s[1] = alu_flags[1];
            calc_flags_s[0] = alu_result[7];
        end
        p_commit_s = (p_r & ~flag_mask(cmd_r)) | (calc_flags_s & flag_mask(cmd_r));
        a_write_s  = writes_acc(cmd_r, acc_sel_r);
    end

    // FSM state register
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Command capture, ALU launch, countdown and architectural commit
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            cnt_r         <= '0;
            cmd_r         <= CMD_PASS;
            acc_sel_r     <= 1'b0;
            bit_nv_r      <= 2'b00;
            a_r           <= 8'h00;
            p_r           <= P_RESET;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 8'h00;
            alu_op_r      <= CMD_PASS;
            alu_acc_r     <= 8'h00;
            alu_operand_r <= 8'h00;
            alu_status_r  <= P_RESET;
        end else begin
            req_ready_r <= (next_state_s == ST_IDLE);
            rsp_valid_r <= (next_state_s == ST_RESP);
            if (accept_s) begin
                cmd_r     <= req_cmd;
                acc_sel_r <= req_acc;
                bit_nv_r  <= req_operand[7:6];
                if (flag_cmd_s) begin
                    p_r        <= p_flag_s;
                    rsp_data_r <= p_flag_s;
                end else begin
                    alu_op_r      <= req_cmd;
                    alu_acc_r     <= a_r;
                    alu_operand_r <= (is_shift(req_cmd) && req_acc) ? a_r : req_operand;
                    alu_status_r  <= p_r;
                    cnt_r         <= CNT_W'(ALU_LAT);
                end
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - CNT_W'(1);
                if (commit_s) begin
                    p_r        <= p_commit_s;
                    rsp_data_r <= alu_result;
                    if (a_write_s) begin
                        a_r <= alu_result;
                    end
                end
            end
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign alu_op      = alu_op_r;
    assign alu_acc     = alu_acc_r;
    assign alu_operand = alu_operand_r;
    assign alu_status  = alu_status_r;
    assign a_out       = a_r;
    assign p_out       = p_r;

endmodule
